// File: rtl/vigenere_decryption_stream.sv
// Vigenere decryption stream: serialises IN_CHARS-wide words MSB-char first and
// subtracts a rotating key schedule. Optional sticky overrun flag: define VIG_OVERRUN_EN.
module vigenere_decryption_stream #(
  parameter int                DATA_W    = 8,
  parameter int                IN_CHARS  = 4,
  parameter int                KEY_DEPTH = 4,
  parameter logic [DATA_W-1:0] TERM_CHAR = 8'hFA,
  localparam int               KEY_IDX_W = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN_CHARS*DATA_W-1:0] data_i,
  input  logic                       valid_i,
  output logic                       busy,
  output logic [DATA_W-1:0]          data_o,
  output logic                       valid_o,
  input  logic                       key_we,
  input  logic [KEY_IDX_W-1:0]       key_addr,
  input  logic [DATA_W-1:0]          key_wdata,
`ifdef VIG_OVERRUN_EN
  input  logic [KEY_IDX_W:0]         key_len,
  output logic                       overrun
`else
  input  logic [KEY_IDX_W:0]         key_len
`endif
);

  localparam int                 WORD_W   = IN_CHARS * DATA_W;
  localparam int                 CNT_W    = (IN_CHARS > 1) ? $clog2(IN_CHARS) : 1;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(IN_CHARS - 1);
  localparam logic [KEY_IDX_W:0] LEN_ONE  = (KEY_IDX_W + 1)'(1);
  localparam logic [KEY_IDX_W:0] LEN_MAX  = (KEY_IDX_W + 1)'(KEY_DEPTH);
  localparam bit                 PARTIAL  = ((2 ** KEY_IDX_W) != KEY_DEPTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                 state;
  logic [WORD_W-1:0]      word_q;
  logic [CNT_W-1:0]       cnt;
  logic [KEY_IDX_W-1:0]   kptr;
  logic [DATA_W-1:0]      key_tbl [KEY_DEPTH];

  logic                   last_char;
  logic [DATA_W-1:0]      cur_char;
  logic                   is_term;
  logic [KEY_IDX_W:0]     eff_len;
  logic                   kptr_wrap;
  logic [KEY_IDX_W-1:0]   kptr_next;
  logic                   key_addr_ok;

  assign last_char = (cnt == LAST_CNT);
  assign busy      = (state == SHIFT) && !last_char;
  // The word register shifts left each char, so the current char is always the top slice.
  assign cur_char  = word_q[WORD_W-1 -: DATA_W];
  assign is_term   = (cur_char == TERM_CHAR);

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    eff_len = key_len;
    if (key_len == '0) begin
      eff_len = LEN_ONE;
    end else if (key_len > LEN_MAX) begin
      eff_len = LEN_MAX;
    end
  end

  // >= rather than == keeps kptr in range when key_len shrinks mid-message.
  assign kptr_wrap = ({1'b0, kptr} >= (eff_len - LEN_ONE));
  assign kptr_next = kptr_wrap ? '0 : kptr + KEY_IDX_W'(1);

  if (PARTIAL) begin : g_addr_chk
    assign key_addr_ok = (int'(key_addr) < KEY_DEPTH);
  end else begin : g_addr_full
    assign key_addr_ok = 1'b1;
  end

  // NOTE: the key table is reset explicitly because the cipher must read zeros after reset;
  // this forces flops rather than a RAM macro, which is acceptable at this depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KEY_DEPTH; i++) begin
        key_tbl[i] <= '0;
      end
    end else if (key_we && key_addr_ok) begin
      key_tbl[key_addr] <= key_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read in this
  // block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      word_q  <= '0;
      cnt     <= '0;
      kptr    <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            word_q <= data_i;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          valid_o <= 1'b1;
          if (is_term) begin
            data_o <= TERM_CHAR;
            kptr   <= '0;
          end else begin
            data_o <= cur_char - key_tbl[kptr];
            kptr   <= kptr_next;
          end
          if (is_term || last_char) begin
            // A word offered on the last-char edge is accepted with no bubble.
            if (last_char && valid_i) begin
              word_q <= data_i;
              cnt    <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            word_q <= word_q << DATA_W;
            cnt    <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VIG_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (valid_i && busy) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vigenere_decryption_stream.sv
// Directed table-driven bench for vigenere_decryption_stream; one row per clock edge.
// Covers VIG_OVERRUN_EN when that macro is defined.
module tb_vigenere_decryption_stream;

  localparam int DATA_W    = 8;
  localparam int IN_CHARS  = 4;
  localparam int KEY_DEPTH = 4;
  localparam int KEY_IDX_W = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [IN_CHARS*DATA_W-1:0] data_i;
  logic                       valid_i;
  logic                       busy;
  logic [DATA_W-1:0]          data_o;
  logic                       valid_o;
  logic                       key_we;
  logic [KEY_IDX_W-1:0]       key_addr;
  logic [DATA_W-1:0]          key_wdata;
  logic [KEY_IDX_W:0]         key_len;
`ifdef VIG_OVERRUN_EN
  logic                       overrun;
`endif

  always #5 clk = ~clk;

  vigenere_decryption_stream #(
    .DATA_W   (DATA_W),
    .IN_CHARS (IN_CHARS),
    .KEY_DEPTH(KEY_DEPTH),
    .TERM_CHAR(8'hFA)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .busy     (busy),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .key_we   (key_we),
    .key_addr (key_addr),
    .key_wdata(key_wdata),
`ifdef VIG_OVERRUN_EN
    .key_len  (key_len),
    .overrun  (overrun)
`else
    .key_len  (key_len)
`endif
  );

  typedef struct {
    logic        rst;
    logic        vi;
    logic [31:0] di;
    logic        kwe;
    logic [1:0]  ka;
    logic [7:0]  kd;
    logic [2:0]  klen;
    logic        evo;
    logic [7:0]  edo;
    logic        ebusy;
  } vec_t;

  vec_t vq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic vi, input logic [31:0] di,
                              input logic kwe, input logic [1:0] ka, input logic [7:0] kd,
                              input logic [2:0] klen, input logic evo, input logic [7:0] edo,
                              input logic ebusy);
    vec_t v;
    v.rst = r; v.vi = vi; v.di = di; v.kwe = kwe; v.ka = ka; v.kd = kd;
    v.klen = klen; v.evo = evo; v.edo = edo; v.ebusy = ebusy;
    return v;
  endfunction

  // Drive inputs, take one edge, sample #1 later and compare.
  task automatic step(input vec_t v, input string tag);
    rst       = v.rst;
    valid_i   = v.vi;
    data_i    = v.di;
    key_we    = v.kwe;
    key_addr  = v.ka;
    key_wdata = v.kd;
    key_len   = v.klen;
    @(posedge clk);
    #1;
    check({tag, " valid_o"}, {31'd0, valid_o}, {31'd0, v.evo});
    if (v.evo || v.rst) check({tag, " data_o"}, {24'd0, data_o}, {24'd0, v.edo});
    check({tag, " busy"}, {31'd0, busy}, {31'd0, v.ebusy});
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; data_i = '0; key_we = 1'b0;
    key_addr = '0; key_wdata = '0; key_len = '0;

    // Reset, single key 3
    vq.push_back(mk(1, 0, 32'h0,        0, 0, 8'h00, 0, 0, 8'h00, 0));
    vq.push_back(mk(0, 0, 32'h0,        1, 0, 8'h03, 1, 0, 8'h00, 0));
    vq.push_back(mk(0, 1, 32'h44454647, 0, 0, 8'h00, 1, 0, 8'h00, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h41, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h42, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h43, 0));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h44, 0));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 0, 8'h00, 0));
    // Terminator mid-word, keys {1,2}; next word restarts at key[0]
    vq.push_back(mk(0, 0, 32'h0,        1, 0, 8'h01, 2, 0, 8'h00, 0));
    vq.push_back(mk(0, 0, 32'h0,        1, 1, 8'h02, 2, 0, 8'h00, 0));
    vq.push_back(mk(0, 1, 32'h42FA4343, 0, 0, 8'h00, 2, 0, 8'h00, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 2, 1, 8'h41, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 2, 1, 8'hFA, 0));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 2, 0, 8'h00, 0));
    vq.push_back(mk(0, 1, 32'h42424242, 0, 0, 8'h00, 2, 0, 8'h00, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 2, 1, 8'h41, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 2, 1, 8'h40, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 2, 1, 8'h41, 0));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 2, 1, 8'h40, 0));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 2, 0, 8'h00, 0));
    // Underflow wrap, key 5; a word offered while busy is ignored
    vq.push_back(mk(0, 0, 32'h0,        1, 0, 8'h05, 1, 0, 8'h00, 0));
    vq.push_back(mk(0, 1, 32'h02020202, 0, 0, 8'h00, 1, 0, 8'h00, 1));
    vq.push_back(mk(0, 1, 32'h11111111, 0, 0, 8'h00, 1, 1, 8'hFD, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'hFD, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'hFD, 0));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'hFD, 0));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 0, 8'h00, 0));
    // Three keys, back-to-back words, schedule spans the word boundary
    vq.push_back(mk(0, 0, 32'h0,        1, 0, 8'h01, 3, 0, 8'h00, 0));
    vq.push_back(mk(0, 0, 32'h0,        1, 1, 8'h02, 3, 0, 8'h00, 0));
    vq.push_back(mk(0, 0, 32'h0,        1, 2, 8'h03, 3, 0, 8'h00, 0));
    vq.push_back(mk(0, 1, 32'h42444642, 0, 0, 8'h00, 3, 0, 8'h00, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 3, 1, 8'h41, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 3, 1, 8'h42, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 3, 1, 8'h43, 0));
    vq.push_back(mk(0, 1, 32'h44464244, 0, 0, 8'h00, 3, 1, 8'h41, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 3, 1, 8'h42, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 3, 1, 8'h43, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 3, 1, 8'h41, 0));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 3, 1, 8'h42, 0));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 3, 0, 8'h00, 0));
    // Shrink key_len to 1 with kptr at 2, then reset mid-word; keys read as 0 afterwards
    vq.push_back(mk(0, 1, 32'h41414141, 0, 0, 8'h00, 1, 0, 8'h00, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h3E, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h40, 1));
    vq.push_back(mk(1, 0, 32'h0,        0, 0, 8'h00, 1, 0, 8'h00, 0));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 0, 8'h00, 0));
    vq.push_back(mk(0, 1, 32'h41414141, 0, 0, 8'h00, 1, 0, 8'h00, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h41, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h41, 1));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h41, 0));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h41, 0));
    vq.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 0, 8'h00, 0));

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i], $sformatf("row%0d", i));
    end

`ifdef VIG_OVERRUN_EN
    check("overrun after reset", {31'd0, overrun}, 32'd0);
`endif
    // Key rewrite mid-word with no stall, plus a dropped word while busy
    step(mk(0, 1, 32'h50505050, 1, 0, 8'h01, 1, 0, 8'h00, 1), "kw0");
    step(mk(0, 1, 32'h99999999, 1, 0, 8'h04, 1, 1, 8'h4F, 1), "kw1");
`ifdef VIG_OVERRUN_EN
    check("overrun set", {31'd0, overrun}, 32'd1);
`endif
    step(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h4C, 1), "kw2");
    step(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h4C, 0), "kw3");
    // Back-to-back into a word whose last char is the terminator, which itself chains a word
    step(mk(0, 1, 32'h414141FA, 0, 0, 8'h00, 1, 1, 8'h4C, 1), "tl0");
    step(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h3D, 1), "tl1");
    step(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h3D, 1), "tl2");
    step(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h3D, 0), "tl3");
    step(mk(0, 1, 32'h45454545, 0, 0, 8'h00, 1, 1, 8'hFA, 1), "tl4");
    step(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h41, 1), "tl5");
    step(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h41, 1), "tl6");
    step(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h41, 0), "tl7");
    step(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 8'h41, 0), "tl8");
    step(mk(0, 0, 32'h0,        0, 0, 8'h00, 1, 0, 8'h00, 0), "tl9");
`ifdef VIG_OVERRUN_EN
    check("overrun sticky", {31'd0, overrun}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
